// File: rtl/mat_loader_pkg.sv
// Shared types for the matrix-multiply accelerator front end.
// Matrix word layout, array depth and loader FSM states.
package acc_pkg;

   typedef logic [3:0][7:0] mat_word_t;

   localparam int MAT_WORDS = 256;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      FIRE,
      WAIT
   } loader_state_t;

endpackage

// File: rtl/mat_loader_if.sv
// Stream, control and matrix bundle between core side and multiplier.
// master drives requests and words; slave is the loader.
interface mat_loader_if #(
   parameter int LEN_W = 8
);
   import acc_pkg::*;

   logic             go;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_ready;
   mat_word_t        mat_A [MAT_WORDS];
   mat_word_t        mat_B [MAT_WORDS];
   logic             start;
   logic             done;
   logic             busy;
   logic             complete;

   modport master (
      output go, len, in_valid, in_data, done,
      input  in_ready, mat_A, mat_B, start, busy, complete
   );

   modport slave (
      input  go, len, in_valid, in_data, done,
      output in_ready, mat_A, mat_B, start, busy, complete
   );

endinterface

// File: rtl/mat_loader.sv
// Fills matrix A then B from a word stream, fires the multiplier,
// and waits for its done before accepting another load.
module mat_loader #(
   parameter int LEN_W = 8
) (
   input logic         clk,
   input logic         rst,
   mat_loader_if.slave bus
);
   import acc_pkg::*;

   loader_state_t    state;
   logic [LEN_W-1:0] idx;
   logic [LEN_W-1:0] len_q;
   logic             in_ready_q;
   logic             start_q;
   logic             busy_q;
   logic             complete_q;
   mat_word_t        a_q [MAT_WORDS];
   mat_word_t        b_q [MAT_WORDS];

   logic xfer;
   logic last;
   logic clr;
   logic we_a;
   logic we_b;

   // len_q of 0 wraps to all-ones, so N=MAT_WORDS ends at MAT_WORDS-1
   assign xfer = bus.in_valid & in_ready_q;
   assign last = (idx == len_q - LEN_W'(1));
   assign clr  = (state == IDLE) & bus.go;
   assign we_a = xfer & (state == LOAD_A);
   assign we_b = xfer & (state == LOAD_B);

   assign bus.in_ready = in_ready_q;
   assign bus.start    = start_q;
   assign bus.busy     = busy_q;
   assign bus.complete = complete_q;
   assign bus.mat_A    = a_q;
   assign bus.mat_B    = b_q;

   // Load sequencer: index counter, handshake and pulse outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         len_q      <= '0;
         in_ready_q <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         complete_q <= 1'b0;
      end else begin
         start_q    <= 1'b0;
         complete_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.go) begin
                  len_q      <= bus.len;
                  idx        <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= LOAD_A;
               end
            end
            LOAD_A: begin
               if (xfer) begin
                  if (last) begin
                     idx   <= '0;
                     state <= LOAD_B;
                  end else begin
                     idx <= idx + LEN_W'(1);
                  end
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  if (last) begin
                     idx        <= '0;
                     in_ready_q <= 1'b0;
                     start_q    <= 1'b1;
                     state      <= FIRE;
                  end else begin
                     idx <= idx + LEN_W'(1);
                  end
               end
            end
            FIRE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (bus.done) begin
                  complete_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

   for (genvar i = 0; i < MAT_WORDS; i++) begin : g_word
      // Per-word storage: cleared on go, written on its indexed transfer
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end else if (clr) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end else begin
            if (we_a && idx == LEN_W'(i)) a_q[i] <= bus.in_data;
            if (we_b && idx == LEN_W'(i)) b_q[i] <= bus.in_data;
         end
      end
   end

endmodule
